// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: sequences one chacha_core through a multi-block job.
// A job command latches key/iv/counter and a block count; each block is
// fetched from the input stream, pushed through the core (init for the
// first block, next for the rest) and returned on the output stream.
// Exactly one block is in flight at a time.
module chacha_stream_ctrl #(
  parameter int NBLK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [255:0]      cmd_key,
  input  logic [63:0]       cmd_iv,
  input  logic [63:0]       cmd_ctr,
  input  logic [NBLK_W-1:0] cmd_nblocks,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [511:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [511:0]      out_data,
  output logic              out_last,
  output logic              core_init,
  output logic              core_next,
  output logic [255:0]      core_key,
  output logic [63:0]       core_iv,
  output logic [63:0]       core_ctr,
  output logic [511:0]      core_data_in,
  input  logic              core_ready,
  input  logic [511:0]      core_data_out,
  input  logic              core_data_out_valid,
  output logic              busy,
  output logic              done,
  output logic [NBLK_W-1:0] blocks_done
);

  typedef enum logic [2:0] {IDLE, LOAD, PULSE, RUN, OUT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [NBLK_W-1:0] remaining;
  logic              first;
  logic              busy_seen;
  logic              capture;
  logic              cmd_fire;
  logic              in_fire;
  logic              out_fire;
  logic              last_blk;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last_blk = (remaining == NBLK_W'(1));
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic plus the handshake and core strobes decoded from state
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // Held low while reset is asserted so every output reads 0 in reset.
        cmd_ready = reset_n;
        if (cmd_valid && reset_n && (cmd_nblocks != '0)) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = core_ready;
        if (in_valid && core_ready) state_nxt = PULSE;
      end
      PULSE: begin
        core_init = first;
        core_next = ~first;
        state_nxt = RUN;
      end
      RUN: begin
        // busy_seen guarantees the core has started this block, so a valid
        // left over from the previous block is never taken as the result.
        capture = busy_seen & core_ready & core_data_out_valid;
        if (capture) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_blk ? IDLE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters and input block latched for the core
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_key     <= '0;
      core_iv      <= '0;
      core_ctr     <= '0;
      core_data_in <= '0;
    end else begin
      if (cmd_fire) begin
        core_key <= cmd_key;
        core_iv  <= cmd_iv;
        core_ctr <= cmd_ctr;
      end
      if (in_fire) core_data_in <= in_data;
    end
  end

  // Job progress: block counters, first-block flag, core-busy observation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining   <= '0;
      blocks_done <= '0;
      first       <= 1'b0;
      busy_seen   <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_fire) begin
        remaining   <= cmd_nblocks;
        blocks_done <= '0;
        first       <= 1'b1;
        done        <= (cmd_nblocks == '0);
      end
      if (state == PULSE) begin
        first     <= 1'b0;
        busy_seen <= 1'b0;
      end
      if ((state == RUN) && !core_ready) busy_seen <= 1'b1;
      if (out_fire) begin
        blocks_done <= blocks_done + NBLK_W'(1);
        remaining   <= remaining - NBLK_W'(1);
        if (last_blk) done <= 1'b1;
      end
    end
  end

  // Output buffer: result held stable until the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
      out_last <= 1'b0;
    end else if (capture) begin
      out_data <= core_data_out;
      out_last <= last_blk;
    end
  end

endmodule

// File: doc/chacha_stream_ctrl.md
Name: chacha_stream_ctrl

Overview:
Sequencer that drives one chacha_core instance through a multi-block stream job. Accepts a job command (key, iv, starting counter, block count) and issues init for block 0 and next for each later block. Feeds 512-bit input blocks from a valid/ready stream and returns each processed block on a valid/ready output stream with a last flag. Sits between the DMA/stream fabric and chacha_core.

Parameters:
NBLK_W, 16, width of the block-count field and the blocks_done counter.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  job request
cmd_ready  out  1  job accepted when cmd_valid & cmd_ready
cmd_key  in  256  job key
cmd_iv  in  64  job IV
cmd_ctr  in  64  starting block counter
cmd_nblocks  in  NBLK_W  blocks in job
in_valid  in  1  input block valid
in_ready  out  1  input block accepted
in_data  in  512  plaintext/ciphertext block
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_data  out  512  result block
out_last  out  1  final block of job (qualified by out_valid)
core_init  out  1  one-cycle init pulse to core
core_next  out  1  one-cycle next pulse to core
core_key  out  256  latched key
core_iv  out  64  latched IV
core_ctr  out  64  latched starting counter
core_data_in  out  512  latched input block
core_ready  in  1  core idle
core_data_out  in  512  core result
core_data_out_valid  in  1  core result valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion
blocks_done  out  NBLK_W  blocks delivered in the current or last job

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE. All outputs 0, including core_key/iv/ctr/data_in, blocks_done and the busy_seen flag. Reset mid-job abandons the job; the core is not pulsed again.
- States: IDLE, LOAD, PULSE, RUN, OUT.
- IDLE: cmd_ready=1.
  - On cmd handshake: latch key/iv/ctr into core_* regs, remaining<=cmd_nblocks, blocks_done<=0, first<=1.
  - If cmd_nblocks==0: done pulses next cycle and state stays IDLE. Otherwise go to LOAD.
- LOAD: in_ready = core_ready.
  - On in handshake: core_data_in<=in_data, go to PULSE.
- PULSE (exactly one cycle): core_init=1 if first, else core_next=1. Then first<=0, busy_seen<=0, go to RUN.
  - core_ctr stays at the job base; the core advances its counter internally on next.
- RUN: busy_seen<=1 when core_ready==0.
  - Capture core_data_out into out buffer only on a cycle with busy_seen==1 (registered from an earlier cycle), core_ready==1 and core_data_out_valid==1. Stale valid from the prior block is thereby ignored.
  - On capture: go to OUT; out_last = (remaining==1).
- OUT: out_valid=1; out_data and out_last are stable until handshake.
  - On out_ready: blocks_done+1, remaining-1.
  - If remaining was 1: done pulses next cycle and state goes to IDLE. Otherwise go to LOAD.
- Only one block is in flight; the controller does not overlap input fetch with core computation.
- Latency per block: in handshake → pulse at +1 cycle → result at core latency + 1 → out_valid the cycle after capture.
- cmd_valid is ignored while busy. Input arriving outside LOAD is not accepted (in_ready=0).
- core_init and core_next are never high together, and each is never high for more than one cycle.
- blocks_done holds its final value after a job until the next cmd handshake.
- Maximum job length is 2^NBLK_W−1 blocks; counter arithmetic on remaining never underflows because the 0 case is handled in IDLE.

Test Plan:
- Single block: key=0123…cdef repeated, iv=deadbeefcafebabe, ctr=0, nblocks=1, in_data={16{deadbeef}}. Expect one core_init pulse and no core_next; out_valid with out_last=1 and out_data equal to the core result; done pulses once; blocks_done=1.
- Ten blocks: ctr=0, block i data={16{deadbeef^i}}. Expect exactly 1 init then 9 next pulses and 10 outputs in order; out_last only on the 10th; blocks_done=10.
- Backpressure: out_ready held 0 for 20 cycles on block 3 of 5. out_valid/out_data/out_last stay stable, in_ready=0 and no core pulse occur during the stall; all 5 blocks complete.
- Stale valid: core model keeps core_data_out_valid=1 from the prior block through PULSE. Controller must not capture until core_ready has dropped and risen again.
- nblocks=0: cmd accepted, no core pulse, no out_valid, done one cycle later, busy never 1.
- Reset mid-job: reset_n=0 during RUN of block 2. All outputs go to 0 immediately, state is IDLE after release, and a new 1-block job then completes normally.
